// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signal bundle for mem_access_unit.
// Latency: none; wires only.
// Backpressure: req_valid/req_ready and resp_valid/resp_ready handshakes.
interface mem_access_unit_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic              mem_write_enabled;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_w_data;
  logic [63:0]       mem_r_data;
  logic              mem_err;

  // Pipeline + memory side.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_r_data, mem_err,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_write_enabled, mem_addr, mem_w_data
  );

  // Access unit side.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_r_data, mem_err,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_write_enabled, mem_addr, mem_w_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store controller between MEM stage and a 64-bit data memory; sub-dword stores use read-modify-write.
// Latency: load/dword store 2 cycles, sub-dword store 3, trapped misaligned 1 (accept edge = 0).
// Backpressure: one request at a time; response held until resp_ready. Option macro: MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int ADDR_W     = 64,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       wbuf_q, wbuf_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] low_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Right-aligned data mask for an access size.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Incoming request decode: offset truncated to natural alignment.
  logic [2:0] req_lmask;
  logic [2:0] req_off;
  logic       trap;
  assign req_lmask = low_mask(bus.req_size);
  assign req_off   = bus.req_addr[2:0] & ~req_lmask;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign trap = |(bus.req_addr[2:0] & req_lmask);
`else
  assign trap = 1'b0;
`endif

  // Lane position of the latched access inside the dword.
  logic [3:0]  nbytes;
  logic [3:0]  lane_w;
  logic [5:0]  shamt;
  logic [63:0] rd_shift;
  logic [63:0] rd_ext;
  logic [63:0] lane_mask;
  logic [63:0] merged;

  assign nbytes    = 4'd1 << size_q;
  assign lane_w    = BIG_ENDIAN ? (4'd8 - {1'b0, addr_q[2:0]} - nbytes) : {1'b0, addr_q[2:0]};
  assign shamt     = {lane_w[2:0], 3'b000};
  assign rd_shift  = bus.mem_r_data >> shamt;
  assign lane_mask = size_mask(size_q) << shamt;
  assign merged    = (bus.mem_r_data & ~lane_mask) | ((wdata_q & size_mask(size_q)) << shamt);

  // Sign/zero extension of the selected load lane.
  always_comb begin
    rd_ext = rd_shift;
    case (size_q)
      2'd0: rd_ext = signed_q ? {{56{rd_shift[7]}},  rd_shift[7:0]}  : {56'd0, rd_shift[7:0]};
      2'd1: rd_ext = signed_q ? {{48{rd_shift[15]}}, rd_shift[15:0]} : {48'd0, rd_shift[15:0]};
      2'd2: rd_ext = signed_q ? {{32{rd_shift[31]}}, rd_shift[31:0]} : {32'd0, rd_shift[31:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  // Next-state and datapath update for the access sequencer.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wbuf_d   = wbuf_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          addr_d   = {bus.req_addr[ADDR_W-1:3], req_off};
          wdata_d  = bus.req_wdata;
          rdata_d  = 64'd0;
          err_d    = 1'b0;
          if (trap) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (bus.req_write && bus.req_size == 2'd3) begin
            state_d = WR;
            wbuf_d  = bus.req_wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (bus.mem_err) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = write_q ? 64'd0 : rd_ext;
        end else if (write_q) begin
          state_d = WR;
          wbuf_d  = merged;
        end else begin
          state_d = RESP;
          rdata_d = rd_ext;
        end
      end
      WR: begin
        state_d = RESP;
        err_d   = bus.mem_err;
        rdata_d = 64'd0;
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 64'd0;
      wbuf_q   <= 64'd0;
      rdata_q  <= 64'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wbuf_q   <= wbuf_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Write strobe decoded from state so it drops the moment reset asserts.
  assign bus.req_ready         = (state_q == IDLE);
  assign bus.resp_valid        = (state_q == RESP);
  assign bus.resp_rdata        = rdata_q;
  assign bus.resp_err          = err_q;
  assign bus.mem_write_enabled = (state_q == WR);
  assign bus.mem_addr          = {addr_q[ADDR_W-1:3], 3'b000};
  assign bus.mem_w_data        = wbuf_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side controller between the pipeline MEM stage and the 64-bit data memory.
- Accepts one load/store request at a time over a valid/ready handshake.
- Drives the memory port: combinational read in the same cycle, write committed on the rising clock edge.
- Byte, half, word and dword accesses with sign/zero extension. Sub-dword stores use read-modify-write. Returns a single response with an error flag.

Parameters:
ADDR_W, 64, request/memory address width
BIG_ENDIAN, 0, 0 = byte lane 0 is addr[2:0]==0 (little endian); 1 = lane order reversed

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
req_valid  input  1  request present
req_ready  output  1  unit can accept request
req_write  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = dword
req_signed  input  1  sign-extend load result
req_addr  input  ADDR_W  byte address
req_wdata  input  64  store data, right-aligned
resp_valid  output  1  response available
resp_ready  input  1  pipeline accepts response
resp_rdata  output  64  load result (0 for stores)
resp_err  output  1  misaligned access or memory error
mem_write_enabled  output  1  memory write strobe
mem_addr  output  ADDR_W  dword-aligned memory address
mem_w_data  output  64  full dword to write
mem_r_data  input  64  memory read data, valid in the same cycle
mem_err  input  1  memory error, sampled with data

Behaviour:
- States: IDLE, RD, WR, RESP. Reset → IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_write_enabled=0, mem_addr=0, mem_w_data=0. Reset mid-operation abandons the access; no write is issued after reset asserts, because mem_write_enabled is decoded from state.
- mem_addr = {latched_addr[ADDR_W-1:3], 3'b000}.
- mem_write_enabled = 1 only in WR. It is 0 in every other state, including RD.
- IDLE:
  - req_ready=1. On req_valid, latch write, size, signed, addr and wdata.
  - Misaligned request (size 1 with addr[0]!=0; size 2 with addr[1:0]!=0; size 3 with addr[2:0]!=0) → RESP with resp_err=1. No memory cycle.
  - Load → RD. Store with size 3 → WR, with mem_w_data=wdata. Store with size <3 → RD.
- RD: capture mem_r_data and mem_err at posedge.
  - Load → RESP. resp_rdata = lane selected by addr[2:0], then sign- or zero-extended to 64 bits per req_signed.
  - Store → WR. Merge the wdata low bytes into the captured dword at the addressed lanes.
  - If mem_err=1, go to RESP with resp_err=1 and skip WR.
- WR: memory commits at the posedge that ends this cycle. mem_err is sampled into resp_err. → RESP.
- RESP:
  - resp_valid=1, req_ready=0.
  - Hold resp_rdata and resp_err stable until resp_ready=1. On handshake → IDLE.
  - No new request is accepted in the handshake cycle; the next accept is one cycle later.
- Latencies (accept edge = 0): load resp_valid at cycle 2; dword store at cycle 2; sub-dword store at cycle 3; misaligned at cycle 1.
- req_ready is 0 in RD, WR and RESP. Request inputs are ignored there.
- Store resp_rdata = 0.

Optional Feature:
MEM_ACCESS_MISALIGN_TRAP_EN
- Defined: misaligned requests produce the error response described in Behaviour.
- Undefined: no misalignment error. The address is truncated down to natural alignment for the size (low bits cleared), then processed normally. resp_err reflects only mem_err.

Test Plan:
- Memory[0x100]=0x8877665544332211; load byte signed at 0x107 → resp_rdata=0xFFFFFFFFFFFFFF88, resp_err=0, resp_valid at cycle 2.
- Same memory; load half unsigned at 0x102 → resp_rdata=0x0000000000004433.
- Store word 0xDEADBEEF at 0x104 → RD cycle then one WR cycle with mem_w_data=0xDEADBEEF44332211; next load dword at 0x100 returns the same value.
- Store dword at 0x101 with trap enabled → resp_err=1 at cycle 1, mem_write_enabled never asserted. With the macro undefined → write to 0x100.
- Hold resp_ready=0 for 5 cycles after a load → resp_valid and resp_rdata stable, req_ready=0, new req_valid ignored.
- Assert reset during the RD of a sub-dword store → state IDLE immediately, mem_write_enabled=0, memory unchanged, req_ready=1.
